square_seq: RTL and testbench
=============================

// Module: square_seq
// PURPOSE
//  Iterative shift-add squarer: the inverse of the structural sqrt datapath.
//  Accepts an unsigned WIDTH-bit operand and returns its exact 2*WIDTH-bit square
//  after a fixed number of cycles.
//  Used as the round-trip partner of sqrt: square(sqrt(x)) <= x and
//  square(sqrt(x)+1) > x, in both self-check and design.
// PARAMETERS
//  WIDTH  8  operand width in bits; result is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//  clk_i    in   1          clock, rising edge
//  rstn_i   in   1          reset, synchronous, active-low
//  enb_i    in   1          synchronous enable; 0 freezes every register
//  start_i  in   1          request a new square of dt_i (sampled when idle and enb_i=1)
//  dt_i     in   WIDTH      unsigned operand
//  busy_o   out  1          1 while an operation is in progress
//  done_o   out  1          1-cycle pulse: dt_o has just been updated with a new result
//  dt_o     out  2*WIDTH    unsigned result dt_i*dt_i, held until next completion
// BEHAVIOUR
//  Reset
//   - rstn_i=0 at a clock edge: state=IDLE, busy_o=0, done_o=0, dt_o=0,
//     internal accumulator/counter/operand regs=0.
//   - Reset has priority over enb_i and start_i; also applies mid-operation
//     (the result is discarded, no done_o).
//  Enable
//   - Every register, including done_o, updates only on edges with enb_i=1.
//   - With enb_i=0 all state and outputs hold; an operation stretches by the
//     number of disabled cycles.
//  FSM (2 states)
//   - IDLE, start_i=1: latch a_q=dt_i (zero-extended to 2*WIDTH),
//     m_q=dt_i, acc_q=0, cnt_q=0 -> CALC.
//   - IDLE, start_i=0: stay in IDLE. done_o=0 on any IDLE edge that is not
//     the completing edge.
//   - CALC, each enabled edge:
//       if m_q[0]: acc_q += a_q;
//       a_q <<= 1; m_q >>= 1; cnt_q++.
//   - CALC, edge with cnt_q==WIDTH-1: dt_o <= final acc (including this step),
//     done_o <= 1, -> IDLE.
//  Timing
//   - busy_o = (state==CALC), registered.
//   - Start accepted at edge E: busy_o is high for exactly WIDTH enabled cycles
//     after E.
//   - At the edge ending the last of those cycles: busy_o falls, done_o rises
//     and dt_o is valid.
//   - Latency from the start edge to the done edge: WIDTH enabled edges.
//  Handshake
//   - start_i is ignored while busy_o=1; dt_i is don't-care after the start edge.
//   - A start_i asserted in the same cycle done_o=1 (state IDLE) is accepted.
//     This gives back-to-back throughput of one result per WIDTH+1 cycles.
//  Arithmetic
//   - acc_q and a_q are 2*WIDTH bits; the maximum result is (2^WIDTH-1)^2,
//     which fits. No overflow or rounding.
//   - cnt_q is clog2(WIDTH)+1 bits wide.
// TESTING
//  1) Reset, then start_i with dt_i=0 -> after 8 cycles done_o=1, dt_o=0.
//  2) dt_i=255 -> dt_o=65025 (0xFE01); busy_o high for exactly 8 cycles.
//  3) dt_i=15 then back-to-back start on the done cycle with dt_i=16
//     -> 225, then 256 nine cycles later.
//  4) start_i held high with dt_i changing during busy -> extra starts ignored;
//     result equals the square of the dt_i latched at start.
//  5) dt_i=100; enb_i=0 for 3 cycles mid-CALC -> outputs frozen; result
//     10000 arrives 3 cycles late.
//  6) rstn_i=0 at CALC cycle 4 -> busy_o=0, dt_o=0, no done_o.
//     Then sweep 0..255 against a golden x*x, and check the sqrt round-trip
//     inequality for every x.

Source files
------------

// File: rtl/square_seq.sv
// Iterative shift-add squarer. Takes an unsigned WIDTH-bit operand and returns its
// exact 2*WIDTH-bit square WIDTH enabled cycles after the start is accepted.
// One multiplier bit is consumed per enabled cycle, LSB first.
module square_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 enb_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     dt_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   dt_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StCalc} state_e;

    state_e               state_q;
    logic [2*WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]     m_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CntW-1:0]      cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   dt_q;
    logic [2*WIDTH-1:0]   acc_step;

    // Accumulator value after the current iteration (add shifted operand if bit set).
    always_comb begin
        acc_step = acc_q;
        if (m_q[0]) begin
            acc_step = acc_q + a_q;
        end
    end

    // Control FSM and datapath; reset wins over enable, enable gates every register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dt_q    <= '0;
        end else if (enb_i) begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= {{WIDTH{1'b0}}, dt_i};
                        m_q     <= dt_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_step;
                    a_q   <= a_q << 1;
                    m_q   <= m_q >> 1;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        // Final iteration: publish the result including this step.
                        dt_q    <= acc_step;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign dt_o   = dt_q;

endmodule

// File: tb/tb_square_seq.sv
// Bench for square_seq: directed scenarios plus random operands with random enable
// gaps, checked against plain x*x and cycle-count expectations.
module tb_square_seq;

    localparam int unsigned W = 8;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic             enb_i = 1'b0;
    logic             start_i = 1'b0;
    logic [W-1:0]     dt_i = '0;
    logic             busy_o;
    logic             done_o;
    logic [2*W-1:0]   dt_o;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned sq [0:255];

    square_seq #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .enb_i   (enb_i),
        .start_i (start_i),
        .dt_i    (dt_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .dt_o    (dt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present an operand with start for one enabled edge; it must be accepted.
    task automatic start_op(input logic [W-1:0] x, input bit hold);
        enb_i   = 1'b1;
        dt_i    = x;
        start_i = 1'b1;
        step();
        if (!hold) start_i = 1'b0;
        check("start_busy", {31'b0, busy_o}, 32'd1);
        check("start_done_low", {31'b0, done_o}, 32'd0);
    endtask

    // Wait for done, counting enabled edges; busy must stay high until then.
    task automatic wait_done(input string tag, input int unsigned exp_val,
                             input int unsigned exp_edges, input bit hold,
                             input bit rand_enb);
        int unsigned edges = 0;
        int unsigned guard = 0;
        bit          en;
        while (done_o !== 1'b1 && guard < 200) begin
            check({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
            if (hold) dt_i = W'($urandom);
            en = rand_enb ? ($urandom_range(0, 3) != 0) : 1'b1;
            enb_i = en;
            step();
            if (en) edges++;
            guard++;
        end
        start_i = 1'b0;
        enb_i   = 1'b1;
        if (guard >= 200) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_latency"}, edges, exp_edges);
        check({tag, "_busy_end"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_value"}, {16'b0, dt_o}, exp_val);
    endtask

    initial begin
        int unsigned prev;
        int unsigned x;
        int unsigned s;

        // Reset has priority over enable and start.
        rstn_i = 1'b0; enb_i = 1'b0; start_i = 1'b1; dt_i = 8'd9;
        step(); step();
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_dt", {16'b0, dt_o}, 32'd0);
        start_i = 1'b0; rstn_i = 1'b1; enb_i = 1'b1;
        step();
        check("idle_busy", {31'b0, busy_o}, 32'd0);

        // Zero operand and the maximum operand.
        start_op(8'd0, 1'b0);
        wait_done("zero", 0, W, 1'b0, 1'b0);
        step();
        check("done_pulse", {31'b0, done_o}, 32'd0);
        start_op(8'd255, 1'b0);
        wait_done("max", 65025, W, 1'b0, 1'b0);

        // Back-to-back: start on the done cycle is accepted, 9 edges apart.
        start_op(8'd15, 1'b0);
        wait_done("b2b_a", 225, W, 1'b0, 1'b0);
        start_op(8'd16, 1'b0);
        wait_done("b2b_b", 256, W, 1'b0, 1'b0);

        // Start held high with dt changing: only the first operand counts.
        start_op(8'd201, 1'b1);
        wait_done("hold", 201 * 201, W, 1'b1, 1'b0);
        step();
        check("hold_no_restart", {31'b0, busy_o}, 32'd0);

        // Enable low for 3 cycles mid-calculation freezes everything.
        start_op(8'd100, 1'b0);
        step(); step(); step();
        prev = {16'b0, dt_o};
        enb_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_busy", {31'b0, busy_o}, 32'd1);
            check("stall_done", {31'b0, done_o}, 32'd0);
            check("stall_dt", {16'b0, dt_o}, prev);
        end
        enb_i = 1'b1;
        wait_done("stall", 10000, W - 3, 1'b0, 1'b0);
        // A disabled edge must also hold the done pulse.
        enb_i = 1'b0;
        step();
        check("done_hold", {31'b0, done_o}, 32'd1);
        enb_i = 1'b1;
        step();
        check("done_clear", {31'b0, done_o}, 32'd0);

        // Reset mid-operation discards the result.
        start_op(8'd77, 1'b0);
        step(); step(); step();
        rstn_i = 1'b0;
        step();
        rstn_i = 1'b1;
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_dt", {16'b0, dt_o}, 32'd0);
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done_o === 1'b1 || busy_o === 1'b1) prev = 1;
        end
        check("midrst_quiet", prev, 32'd0);

        // Exhaustive sweep against x*x.
        for (int i = 0; i < 256; i++) begin
            start_op(W'(i), 1'b0);
            wait_done("sweep", i * i, W, 1'b0, 1'b0);
            sq[i] = {16'b0, dt_o};
        end

        // sqrt round trip using the DUT's own squares.
        for (int i = 0; i < 256; i++) begin
            s = 0;
            while ((s + 1) * (s + 1) <= i) s++;
            check("rt_lo", {31'b0, sq[s] <= i}, 32'd1);
            check("rt_hi", {31'b0, sq[s + 1] > i}, 32'd1);
        end

        // Random operands with random enable gaps.
        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(0, 255);
            start_op(W'(x), 1'b0);
            wait_done("rand", x * x, W, 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
